// File: rtl/mul_accumulator.sv
// mul_accumulator
//   Collects N_TERMS products from the shift-add multiplier stage into a
//   saturating sum and hands the sum downstream over a valid/ready handshake.
//   A product is taken once per rising edge of prod_valid, however long the
//   level is held.
//
// Ports
//   CLK         in   1       system clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   prod_in     in   PROD_W  unsigned product from the multiplier
//   prod_valid  in   1       multiplier out_valid (level)
//   clear       in   1       synchronous abort of the sum in progress
//   sum_out     out  ACC_W   accumulated sum, stable while sum_valid=1
//   sum_valid   out  1       sum available
//   sum_ready   in   1       downstream accepts the sum
//   count_out   out  CNT_W   products accumulated in the current sum
//   overflow    out  1       sum saturated (sticky until accepted/cleared)
module mul_accumulator #(
  parameter int unsigned PROD_W  = 16,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned N_TERMS = 4,
  localparam int unsigned CNT_W  = $clog2(N_TERMS + 1)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  input  logic              clear,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [CNT_W-1:0]  count_out,
  output logic              overflow
);

  // One extra bit above the accumulator catches the carry used for saturation.
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic               ovf;
  logic               ovf_nxt;
  logic               valid;
  logic               valid_nxt;
  logic               prev_valid;

  logic               capture;
  logic [SUM_W-1:0]   add_res;
  logic [CNT_W-1:0]   count_inc;

  // Rising edge of the multiplier's valid level is the only capture event.
  assign capture   = prod_valid & ~prev_valid;
  assign add_res   = {1'b0, acc} + SUM_W'(prod_in);
  assign count_inc = count + CNT_W'(1);

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-datapath values.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;
    valid_nxt = valid;

    if (clear) begin
      // Abort wins over everything but reset; a coincident capture is lost.
      state_nxt = ST_ACCUM;
      acc_nxt   = '0;
      count_nxt = '0;
      ovf_nxt   = 1'b0;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (capture) begin
            if (add_res[ACC_W]) begin
              acc_nxt = '1;
              ovf_nxt = 1'b1;
            end else begin
              acc_nxt = add_res[ACC_W-1:0];
            end
            count_nxt = count_inc;
            if (count_inc == CNT_W'(N_TERMS)) begin
              state_nxt = ST_HOLD;
              valid_nxt = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Captures are dropped here, including one coincident with the accept.
          if (sum_ready) begin
            state_nxt = ST_ACCUM;
            acc_nxt   = '0;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
            valid_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt = ST_ACCUM;
        end
      endcase
    end
  end

  // Datapath registers; prev_valid tracks the input in every state.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      valid      <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      count      <= count_nxt;
      ovf        <= ovf_nxt;
      valid      <= valid_nxt;
      prev_valid <= prod_valid;
    end
  end

  assign sum_out   = acc;
  assign sum_valid = valid;
  assign count_out = count;
  assign overflow  = ovf;

endmodule

// File: tb/tb_mul_accumulator.sv
// Bench for mul_accumulator: two instances share one stimulus stream
// (24-bit/4-term and 16-bit/2-term). Expected sums come from plain integer
// totals clipped at the accumulator maximum.
module tb_mul_accumulator;

  localparam int unsigned PROD_W  = 16;
  localparam int unsigned ACC_W_A = 24;
  localparam int unsigned N_A     = 4;
  localparam int unsigned ACC_W_B = 16;
  localparam int unsigned N_B     = 2;
  localparam int unsigned CNT_W_A = $clog2(N_A + 1);
  localparam int unsigned CNT_W_B = $clog2(N_B + 1);

  logic                clk = 1'b0;
  logic                reset;
  logic [PROD_W-1:0]   prod_in;
  logic                prod_valid;
  logic                clear;
  logic                sum_ready;

  logic [ACC_W_A-1:0]  sum_out_a;
  logic                sum_valid_a;
  logic [CNT_W_A-1:0]  count_out_a;
  logic                overflow_a;
  logic [ACC_W_B-1:0]  sum_out_b;
  logic                sum_valid_b;
  logic [CNT_W_B-1:0]  count_out_b;
  logic                overflow_b;

  always #5 clk = ~clk;

  mul_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W_A), .N_TERMS(N_A)) u_dut_a (
    .CLK(clk), .reset(reset), .prod_in(prod_in), .prod_valid(prod_valid),
    .clear(clear), .sum_out(sum_out_a), .sum_valid(sum_valid_a),
    .sum_ready(sum_ready), .count_out(count_out_a), .overflow(overflow_a)
  );

  mul_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W_B), .N_TERMS(N_B)) u_dut_b (
    .CLK(clk), .reset(reset), .prod_in(prod_in), .prod_valid(prod_valid),
    .clear(clear), .sum_out(sum_out_b), .sum_valid(sum_valid_b),
    .sum_ready(sum_ready), .count_out(count_out_b), .overflow(overflow_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, products taken so far and their exact total.
  int              terms [2];
  longint unsigned total [2];
  bit              hold  [2];
  longint unsigned q_sum_a [$];
  longint unsigned q_sum_b [$];
  bit              q_ovf_a [$];
  bit              q_ovf_b [$];

  function automatic int unsigned n_of(input int u);
    return (u == 0) ? N_A : N_B;
  endfunction

  function automatic longint unsigned max_of(input int u);
    return (u == 0) ? ((64'd1 << ACC_W_A) - 64'd1) : ((64'd1 << ACC_W_B) - 64'd1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // A new pulse is taken unless the instance is presenting a finished sum.
  function automatic void model_pulse(input longint unsigned p);
    longint unsigned s;
    for (int u = 0; u < 2; u++) begin
      if (!hold[u]) begin
        total[u] += p;
        terms[u]++;
        if (terms[u] == int'(n_of(u))) begin
          s = (total[u] > max_of(u)) ? max_of(u) : total[u];
          if (u == 0) begin
            q_sum_a.push_back(s);
            q_ovf_a.push_back(total[u] > max_of(u));
          end else begin
            q_sum_b.push_back(s);
            q_ovf_b.push_back(total[u] > max_of(u));
          end
          hold[u]  = 1'b1;
          terms[u] = 0;
          total[u] = 0;
        end
      end
    end
  endfunction

  function automatic void model_edges_done();
    if (sum_ready) begin
      hold[0] = 1'b0;
      hold[1] = 1'b0;
    end
  endfunction

  function automatic void model_abort();
    for (int u = 0; u < 2; u++) begin
      if (hold[u]) begin
        if (u == 0) begin
          void'(q_sum_a.pop_back());
          void'(q_ovf_a.pop_back());
        end else begin
          void'(q_sum_b.pop_back());
          void'(q_ovf_b.pop_back());
        end
      end
      hold[u]  = 1'b0;
      terms[u] = 0;
      total[u] = 0;
    end
  endfunction

  task automatic check_state();
    check("count_a", 64'(count_out_a), 64'(hold[0] ? N_A : int'(terms[0])));
    check("valid_a", 64'(sum_valid_a), 64'(hold[0]));
    check("count_b", 64'(count_out_b), 64'(hold[1] ? N_B : int'(terms[1])));
    check("valid_b", 64'(sum_valid_b), 64'(hold[1]));
  endtask

  // Valid high for hi edges, then low for one edge.
  task automatic send(input longint unsigned p, input int hi);
    model_pulse(p);
    prod_in    = PROD_W'(p);
    prod_valid = 1'b1;
    repeat (hi) @(posedge clk);
    #1 prod_valid = 1'b0;
    @(posedge clk);
    #1;
    model_edges_done();
    check_state();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
    model_edges_done();
    check_state();
  endtask

  task automatic do_clear(input longint unsigned p);
    prod_in    = PROD_W'(p);
    prod_valid = 1'b1;
    clear      = 1'b1;
    @(posedge clk);
    #1;
    clear      = 1'b0;
    prod_valid = 1'b0;
    model_abort();
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic check_all_zero();
    check("rst_sum_a",   64'(sum_out_a),   64'd0);
    check("rst_valid_a", 64'(sum_valid_a), 64'd0);
    check("rst_count_a", 64'(count_out_a), 64'd0);
    check("rst_ovf_a",   64'(overflow_a),  64'd0);
    check("rst_sum_b",   64'(sum_out_b),   64'd0);
    check("rst_valid_b", 64'(sum_valid_b), 64'd0);
    check("rst_count_b", 64'(count_out_b), 64'd0);
    check("rst_ovf_b",   64'(overflow_b),  64'd0);
  endtask

  // Reset asserted between edges: outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_all_zero();
    model_abort();
    #19 reset = 1'b0;
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Monitor: any presented sum must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && sum_valid_a) begin
      if (q_sum_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sum_a actual=%0d required=none at %0t", sum_out_a, $time);
      end else begin
        check("sum_a", 64'(sum_out_a), 64'(q_sum_a[0]));
        check("ovf_a", 64'(overflow_a), 64'(q_ovf_a[0]));
        check("hold_count_a", 64'(count_out_a), 64'(N_A));
        if (sum_ready) begin
          void'(q_sum_a.pop_front());
          void'(q_ovf_a.pop_front());
        end
      end
    end
    if (!reset && sum_valid_b) begin
      if (q_sum_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sum_b actual=%0d required=none at %0t", sum_out_b, $time);
      end else begin
        check("sum_b", 64'(sum_out_b), 64'(q_sum_b[0]));
        check("ovf_b", 64'(overflow_b), 64'(q_ovf_b[0]));
        check("hold_count_b", 64'(count_out_b), 64'(N_B));
        if (sum_ready) begin
          void'(q_sum_b.pop_front());
          void'(q_ovf_b.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint unsigned p;
    int r;
    for (int u = 0; u < 2; u++) begin
      terms[u] = 0;
      total[u] = 0;
      hold[u]  = 1'b0;
    end
    reset      = 1'b1;
    prod_in    = '0;
    prod_valid = 1'b0;
    clear      = 1'b0;
    sum_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero();
    reset = 1'b0;
    @(posedge clk);
    #1 check_state();

    // Four one-cycle pulses with ready high: A sums to 1028.
    send(27, 1); send(0, 1); send(140, 1); send(861, 1);

    // Level held six cycles counts once.
    send(60, 6);
    check("held_level_count_a", 64'(count_out_a), 64'd1);
    send(5, 1); send(7, 2); send(8, 1);

    // Stall in HOLD; extra pulses are dropped, including one rising at the accept edge.
    sum_ready = 1'b0;
    send(27, 1); send(0, 1); send(140, 1); send(861, 1);
    send(111, 1); send(222, 1);
    idle(10);
    check("stalled_sum_a", 64'(sum_out_a), 64'd1028);
    sum_ready = 1'b1;
    send(333, 2);
    send(1, 1); send(1, 1); send(1, 1); send(1, 1);

    // Saturation on the 16-bit instance, then a clean sum after the handshake.
    send(64'hFFFF, 1); send(64'h0002, 1);
    send(0, 1); send(3, 1);

    // Reset mid-accumulation discards the partial sum.
    send(3, 1); send(5, 1);
    do_reset();
    send(1, 1); send(1, 1); send(1, 1); send(1, 1);

    // Clear coincident with a capture event.
    send(9, 1);
    do_clear(77);
    send(10, 1); send(20, 1); send(30, 1); send(40, 1);

    // Randomized traffic with occasional back-pressure.
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) sum_ready = 1'b0;
      else if (r < 4) sum_ready = 1'b1;
      if ($urandom_range(0, 1) == 0) p = longint'($urandom_range(0, 65535));
      else p = longint'($urandom_range(0, 255)) * longint'($urandom_range(0, 255));
      send(p, int'($urandom_range(1, 3)));
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
    end
    sum_ready = 1'b1;
    idle(2);
    send(4, 1); send(4, 1); send(4, 1); send(4, 1);
    idle(2);

    check("left_a", 64'(q_sum_a.size()), 64'd0);
    check("left_b", 64'(q_sum_b.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
